uart_mem_dump: RTL and testbench
================================

Name: uart_mem_dump

Overview:
- RIB bus master that reads a contiguous block of memory and streams it out over a UART TX pin.
- It is the reader counterpart of uart_debug, which writes memory from UART; together they give a host a download/readback pair.
- It sits on a spare RIB master port alongside uart_debug and uses the same req/we/addr/wdata/rdata master signalling.
- Output framing: 4 bytes per word, little-endian, followed by one XOR checksum byte.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, UART bit rate.
- BAUD_DIV, CLK_FREQ/BAUD, clocks per UART bit. Must be >= 4.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-low reset.
- dump_en_i, input, 1, rising edge starts a dump; low level aborts one in progress.
- start_addr_i, input, 32, first byte address of the dump; bits [1:0] are ignored.
- word_cnt_i, input, 16, number of 32-bit words to send.
- req_o, output, 1, RIB master request.
- mem_we_o, output, 1, RIB write enable; always 0.
- mem_addr_o, output, 32, RIB address.
- mem_wdata_o, output, 32, RIB write data; always 0.
- mem_rdata_i, input, 32, RIB read data (combinational from the slave).
- tx_pin, output, 1, UART TX line, 8N1, idle high.
- busy_o, output, 1, high from start until done or abort.
- done_o, output, 1, one-cycle pulse after the checksum stop bit completes.

Behaviour:
- Reset values: tx_pin=1; req_o=0; mem_we_o=0; mem_addr_o=0; mem_wdata_o=0; busy_o=0; done_o=0; all internal counters and the checksum register = 0.
- Start:
  - dump_en_i is sampled into a register each cycle.
  - A rising edge seen in IDLE latches addr = {start_addr_i[31:2], 2'b00}, cnt = word_cnt_i, csum = 0, and sets busy_o.
  - Edges seen outside IDLE are ignored.
- FSM states: IDLE -> (cnt==0 ? CSUM : REQ) -> LATCH -> SEND(x4) -> NEXT -> REQ ... -> CSUM -> FIN -> IDLE.
- REQ (1 cycle): req_o=1, mem_addr_o=addr.
- LATCH (1 cycle): req_o stays 1 and the address stays stable. At the end of the cycle, mem_rdata_i is captured into the word register. req_o drops on the next cycle.
- SEND:
  - Sends byte 0 = word[7:0] first, through byte 3 = word[31:24].
  - Each byte: csum ^= byte, then hand it to the uart_tx_byte sub-module.
  - The next byte's start bit begins the cycle after the previous stop bit's final cycle, so there are no idle gaps inside a word.
- NEXT (1 cycle): addr += 4, wrapping modulo 2^32 (0xFFFFFFFC -> 0x00000000); cnt -= 1. Go to REQ if cnt != 0, else CSUM.
- CSUM: sends the csum byte. If word_cnt_i was 0, exactly one byte 0x00 is sent.
- FIN (1 cycle): done_o=1, busy_o=0, return to IDLE.
- UART bit timing:
  - Each bit lasts exactly BAUD_DIV clocks.
  - Frame = start bit 0, then 8 data bits LSB first, then stop bit 1, i.e. 10*BAUD_DIV clocks per byte.
- Abort:
  - dump_en_i low while busy finishes the current byte, including its stop bit, then goes to IDLE.
  - No checksum is sent, done_o is not pulsed, and busy_o clears when IDLE is entered.
  - req_o is never left asserted.
- mem_we_o and mem_wdata_o are held at 0 at all times.
- Reset mid-operation: all outputs return immediately to their reset values, with tx_pin forced high. A partially sent byte is not completed.

Decomposition:
- Shared defines header:
  - RIB bus width macros (MemAddrBus, MemBus).
  - Read-only master constants (WriteDisable, ZeroWord).
- Local constants: FSM state encoding and UART frame length of 10 bits.
- One sub-module, uart_tx_byte:
  - Handles baud counting, the 10-bit shift register and the tx pin.
  - Interface: start_i, data_i[7:0], busy_o, tx_o.
  - Takes the same clk and rst.

Test Plan (CLK_FREQ=1000000, BAUD=100000, so BAUD_DIV=10):
- Memory model 0x00000100=0x44332211. start_addr=0x100, cnt=1. Pulse dump_en_i.
  - Expect one req for 2 cycles at 0x100.
  - Expect tx bytes 0x11, 0x22, 0x33, 0x44, then checksum 0x44.
  - Expect each bit exactly 10 clocks, done_o pulsed once, busy_o=0 afterwards.
- start_addr=0x103, cnt=2, memory 0x100=0x000000FF, 0x104=0x0000FF00.
  - Expect addresses 0x100 then 0x104.
  - Expect bytes FF 00 00 00 00 FF 00 00, then checksum 0x00.
- start_addr=0xFFFFFFFC, cnt=2.
  - Expect the second request at 0x00000000, confirming wrap-around.
- cnt=0.
  - Expect no req_o, a single tx byte 0x00, then done_o.
- cnt=3. Drop dump_en_i mid-way through byte 2 of word 0.
  - Expect that byte's frame to complete with a correct stop bit.
  - Expect no further req or tx activity, done_o=0, busy_o=0.
- Assert rst low during a start bit.
  - Expect tx_pin=1 and req_o=0 immediately.
  - After release, a new dump runs normally. A second rising edge applied while busy has no effect.

Source files
------------

// File: rtl/uart_mem_dump_pkg.sv
// uart_mem_dump shared constants and types.
// RIB master widths, read-only constants, FSM states.
package uart_mem_dump_pkg;

  localparam int MemAddrBus = 32;
  localparam int MemBus     = 32;

  localparam logic              WriteDisable = 1'b0;
  localparam logic [MemBus-1:0] ZeroWord     = '0;

  localparam int FrameBits = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_LATCH,
    S_SEND,
    S_NEXT,
    S_CSUM,
    S_FIN
  } state_e;

endpackage

// File: rtl/uart_mem_dump_tx_byte.sv
// uart_tx_byte: 8N1 serializer with baud counter.
// busy_o drops in the final stop-bit clock so frames can abut.
module uart_tx_byte
  import uart_mem_dump_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       busy_o,
  output logic       tx_o
);

  logic [FrameBits-1:0] shift_q, shift_d;
  logic [3:0]           bit_q, bit_d;
  logic [15:0]          baud_q, baud_d;
  logic                 act_q, act_d;
  logic                 bit_end;
  logic                 last;

  assign bit_end = baud_q == 16'(BAUD_DIV - 1);
  assign last    = act_q && bit_end
                && bit_q == 4'(FrameBits - 1);
  assign busy_o  = act_q && !last;
  assign tx_o    = act_q ? shift_q[0] : 1'b1;

  // load a new frame or advance baud/bit counters
  always_comb begin
    shift_d = shift_q;
    bit_d   = bit_q;
    baud_d  = baud_q;
    act_d   = act_q;
    if (start_i && !busy_o) begin
      shift_d = {1'b1, data_i, 1'b0};
      bit_d   = '0;
      baud_d  = '0;
      act_d   = 1'b1;
    end else if (act_q) begin
      if (bit_end) begin
        baud_d = '0;
        if (last) begin
          act_d = 1'b0;
        end else begin
          bit_d   = bit_q + 4'd1;
          shift_d = {1'b1, shift_q[FrameBits-1:1]};
        end
      end else begin
        baud_d = baud_q + 16'd1;
      end
    end
  end

  // serializer state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= '0;
      bit_q   <= '0;
      baud_q  <= '0;
      act_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      bit_q   <= bit_d;
      baud_q  <= baud_d;
      act_q   <= act_d;
    end
  end

endmodule

// File: rtl/uart_mem_dump.sv
// uart_mem_dump: RIB read master streaming words over UART.
// Little-endian bytes per word, then one XOR checksum byte.
module uart_mem_dump
  import uart_mem_dump_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned BAUD     = 115200,
  parameter int unsigned BAUD_DIV = CLK_FREQ / BAUD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dump_en_i,
  input  logic [MemAddrBus-1:0] start_addr_i,
  input  logic [15:0]           word_cnt_i,
  output logic                  req_o,
  output logic                  mem_we_o,
  output logic [MemAddrBus-1:0] mem_addr_o,
  output logic [MemBus-1:0]     mem_wdata_o,
  input  logic [MemBus-1:0]     mem_rdata_i,
  output logic                  tx_pin,
  output logic                  busy_o,
  output logic                  done_o
);

  state_e                state_q, state_d;
  logic                  en_q;
  logic [MemAddrBus-1:0] addr_q, addr_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [7:0]            csum_q, csum_d;
  logic [MemBus-1:0]     word_q, word_d;
  logic [1:0]            bidx_q, bidx_d;
  logic                  sent_q, sent_d;
  logic                  tx_start;
  logic [7:0]            tx_data;
  logic                  tx_busy;
  logic [7:0]            cur_byte;

  assign cur_byte    = word_q[{bidx_q, 3'b000} +: 8];
  assign mem_we_o    = WriteDisable;
  assign mem_wdata_o = ZeroWord;
  assign mem_addr_o  = req_o ? addr_q : ZeroWord;
  assign busy_o      = state_q != S_IDLE
                    && state_q != S_FIN;

  // next state; abort is only honoured at byte boundaries
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    csum_d   = csum_q;
    word_d   = word_q;
    bidx_d   = bidx_q;
    sent_d   = sent_q;
    tx_start = 1'b0;
    tx_data  = cur_byte;
    req_o    = 1'b0;
    done_o   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (dump_en_i && !en_q) begin
          addr_d  = start_addr_i & ~32'h3;
          cnt_d   = word_cnt_i;
          csum_d  = '0;
          sent_d  = 1'b0;
          state_d = (word_cnt_i == 16'd0) ? S_CSUM
                                          : S_REQ;
        end
      end
      S_REQ: begin
        req_o   = 1'b1;
        state_d = S_LATCH;
      end
      S_LATCH: begin
        req_o   = 1'b1;
        word_d  = mem_rdata_i;
        bidx_d  = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (!tx_busy) begin
          if (!dump_en_i) begin
            state_d = S_IDLE;
          end else begin
            tx_start = 1'b1;
            csum_d   = csum_q ^ cur_byte;
            bidx_d   = bidx_q + 2'd1;
            if (bidx_q == 2'd3) state_d = S_NEXT;
          end
        end
      end
      S_NEXT: begin
        addr_d  = addr_q + 32'd4;
        cnt_d   = cnt_q - 16'd1;
        state_d = (cnt_q == 16'd1) ? S_CSUM : S_REQ;
      end
      S_CSUM: begin
        tx_data = csum_q;
        if (!tx_busy) begin
          if (sent_q) begin
            state_d = S_FIN;
          end else if (!dump_en_i) begin
            state_d = S_IDLE;
          end else begin
            tx_start = 1'b1;
            sent_d   = 1'b1;
          end
        end
      end
      S_FIN: begin
        done_o  = 1'b1;
        sent_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      en_q    <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      csum_q  <= '0;
      word_q  <= '0;
      bidx_q  <= '0;
      sent_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= dump_en_i;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
      word_q  <= word_d;
      bidx_q  <= bidx_d;
      sent_q  <= sent_d;
    end
  end

  uart_tx_byte #(
    .BAUD_DIV (BAUD_DIV)
  ) u_tx (
    .clk     (clk),
    .rst     (rst),
    .start_i (tx_start),
    .data_i  (tx_data),
    .busy_o  (tx_busy),
    .tx_o    (tx_pin)
  );

endmodule

// File: tb/tb_uart_mem_dump.sv
// Directed bench for uart_mem_dump at BAUD_DIV=10.
// Decodes tx_pin at mid-bit and checks bus/handshake counts.
module tb_uart_mem_dump;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dump_en = 1'b0;
  logic [31:0] start_addr = '0;
  logic [15:0] word_cnt = '0;
  logic        req_o, mem_we_o, tx_pin, busy_o, done_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata;

  logic [31:0] m100, m104, m108, mtop, m0;

  int tests = 0;
  int fails = 0;

  int          req_cycles = 0;
  int          req_rise = 0;
  int          done_cnt = 0;
  logic        req_prev = 1'b0;
  logic [31:0] addr_log [4];

  logic [7:0]  exp_b [10];
  int          drop_mode = 0;

  always #5 clk = ~clk;

  uart_mem_dump #(
    .CLK_FREQ (1000000),
    .BAUD     (100000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .dump_en_i    (dump_en),
    .start_addr_i (start_addr),
    .word_cnt_i   (word_cnt),
    .req_o        (req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata),
    .tx_pin       (tx_pin),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always_comb begin
    case (mem_addr_o)
      32'h0000_0100: mem_rdata = m100;
      32'h0000_0104: mem_rdata = m104;
      32'h0000_0108: mem_rdata = m108;
      32'hFFFF_FFFC: mem_rdata = mtop;
      32'h0000_0000: mem_rdata = m0;
      default:       mem_rdata = 32'hDEAD_BEEF;
    endcase
  end

  always @(posedge clk) begin
    if (req_o) begin
      req_cycles++;
      if (!req_prev) begin
        if (req_rise < 4) addr_log[req_rise] = mem_addr_o;
        req_rise++;
      end
    end
    req_prev = req_o;
    if (done_o) done_cnt++;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rx_byte(input int drop_bit,
                         output logic [7:0] b,
                         output int gap,
                         output logic stop_ok);
    int   w;
    logic start_ok;
    w = 0;
    b = '0;
    stop_ok = 1'b0;
    do begin
      @(negedge clk);
      w++;
    end while (tx_pin !== 1'b0 && w < 3000);
    gap = w;
    if (w >= 3000) begin
      check("rx_start_timeout", 32'(w), 32'd0);
      return;
    end
    repeat (4) @(negedge clk);
    start_ok = (tx_pin === 1'b0);
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (i == drop_bit && drop_mode != 0 && k == 1)
          dump_en = 1'b0;
        if (i == drop_bit && drop_mode == 2 && k == 4)
          dump_en = 1'b1;
      end
      b[i] = tx_pin;
    end
    repeat (10) @(negedge clk);
    stop_ok = (tx_pin === 1'b1) && start_ok;
  endtask

  task automatic clear_mon();
    req_cycles = 0;
    req_rise   = 0;
    done_cnt   = 0;
    for (int i = 0; i < 4; i++) addr_log[i] = '0;
  endtask

  task automatic run_dump(input string tag,
                          input logic [31:0] sa,
                          input logic [15:0] cnt,
                          input int nbytes,
                          input int drop_byte);
    logic [7:0] b;
    int         gap;
    logic       ok;
    @(negedge clk);
    dump_en = 1'b0;
    @(negedge clk);
    clear_mon();
    start_addr = sa;
    word_cnt   = cnt;
    dump_en    = 1'b1;
    for (int i = 0; i < nbytes; i++) begin
      rx_byte((i == drop_byte) ? 3 : -1, b, gap, ok);
      check($sformatf("%s_byte%0d", tag, i), 32'(b), 32'(exp_b[i]));
      check($sformatf("%s_stop%0d", tag, i), 32'(ok), 32'd1);
      if ((i % 4) != 0 && i < 4 * int'(cnt))
        check($sformatf("%s_gap%0d", tag, i), 32'(gap), 32'd6);
    end
  endtask

  task automatic tail(input string tag);
    for (int k = 0; k < 30 && done_cnt < 1; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    check({tag, "_done"}, 32'(done_cnt), 32'd1);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_tx_idle"}, 32'(tx_pin), 32'd1);
    check({tag, "_we"}, 32'(mem_we_o), 32'd0);
    check({tag, "_wdata"}, mem_wdata_o, 32'd0);
  endtask

  initial begin
    int lows;
    m100 = 32'h4433_2211;
    m104 = 32'h0000_FF00;
    m108 = 32'h5555_5555;
    mtop = 32'h0102_0304;
    m0   = 32'hA0B0_C0D0;

    #2 rst = 1'b0;
    #1;
    check("rst_tx", 32'(tx_pin), 32'd1);
    check("rst_req", 32'(req_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_addr", mem_addr_o, 32'd0);
    check("rst_we", 32'(mem_we_o), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    exp_b[0] = 8'h11; exp_b[1] = 8'h22;
    exp_b[2] = 8'h33; exp_b[3] = 8'h44;
    exp_b[4] = 8'h44;
    run_dump("t1", 32'h100, 16'd1, 5, -1);
    tail("t1");
    check("t1_req_rise", 32'(req_rise), 32'd1);
    check("t1_req_cycles", 32'(req_cycles), 32'd2);
    check("t1_addr0", addr_log[0], 32'h100);

    m100 = 32'h0000_00FF;
    exp_b[0] = 8'hFF; exp_b[1] = 8'h00;
    exp_b[2] = 8'h00; exp_b[3] = 8'h00;
    exp_b[4] = 8'h00; exp_b[5] = 8'hFF;
    exp_b[6] = 8'h00; exp_b[7] = 8'h00;
    exp_b[8] = 8'h00;
    run_dump("t2", 32'h103, 16'd2, 9, -1);
    tail("t2");
    check("t2_req_rise", 32'(req_rise), 32'd2);
    check("t2_addr0", addr_log[0], 32'h100);
    check("t2_addr1", addr_log[1], 32'h104);
    check("t2_req_cycles", 32'(req_cycles), 32'd4);

    exp_b[0] = 8'h04; exp_b[1] = 8'h03;
    exp_b[2] = 8'h02; exp_b[3] = 8'h01;
    exp_b[4] = 8'hD0; exp_b[5] = 8'hC0;
    exp_b[6] = 8'hB0; exp_b[7] = 8'hA0;
    exp_b[8] = 8'h04;
    run_dump("t3", 32'hFFFF_FFFC, 16'd2, 9, -1);
    tail("t3");
    check("t3_addr0", addr_log[0], 32'hFFFF_FFFC);
    check("t3_addr1", addr_log[1], 32'h0000_0000);

    exp_b[0] = 8'h00;
    run_dump("t4", 32'h100, 16'd0, 1, -1);
    tail("t4");
    check("t4_req_rise", 32'(req_rise), 32'd0);

    m100 = 32'h4433_2211;
    exp_b[0] = 8'h11; exp_b[1] = 8'h22;
    exp_b[2] = 8'h33;
    drop_mode = 1;
    run_dump("t5", 32'h100, 16'd3, 3, 2);
    drop_mode = 0;
    lows = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (tx_pin !== 1'b1) lows++;
    end
    check("t5_tx_quiet", 32'(lows), 32'd0);
    check("t5_done", 32'(done_cnt), 32'd0);
    check("t5_busy", 32'(busy_o), 32'd0);
    check("t5_req_rise", 32'(req_rise), 32'd1);
    check("t5_req_cycles", 32'(req_cycles), 32'd2);
    check("t5_req_low", 32'(req_o), 32'd0);

    @(negedge clk);
    start_addr = 32'h100;
    word_cnt   = 16'd1;
    dump_en    = 1'b1;
    lows = 0;
    while (tx_pin !== 1'b0 && lows < 100) begin
      @(negedge clk);
      lows++;
    end
    check("t6_saw_start", 32'(tx_pin), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    dump_en = 1'b0;
    #1;
    check("t6_rst_tx", 32'(tx_pin), 32'd1);
    check("t6_rst_req", 32'(req_o), 32'd0);
    check("t6_rst_busy", 32'(busy_o), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    exp_b[0] = 8'h11; exp_b[1] = 8'h22;
    exp_b[2] = 8'h33; exp_b[3] = 8'h44;
    exp_b[4] = 8'h44;
    drop_mode = 2;
    run_dump("t6", 32'h100, 16'd1, 5, 1);
    drop_mode = 0;
    tail("t6");
    check("t6_req_rise", 32'(req_rise), 32'd1);
    lows = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (tx_pin !== 1'b1 || req_o !== 1'b0) lows++;
    end
    check("t6_no_restart", 32'(lows), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
